// File: rtl/result_buffer.sv
// result_buffer: single-clock result RAM with independent write and read
// ports, per-entry valid bits, an occupancy count, selectable
// read-during-write behaviour and a hardware clear sweep that zeroes the
// array after reset or on command.
module result_buffer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int WRITE_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic              busy,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_SWEEP,
    ST_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_ptr_q, sweep_ptr_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_hit_q, rd_hit_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                fwd_hit;

  // Next-state, array write port and registered read path
  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    valid_d     = valid_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_hit_d    = rd_hit_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    // A write that will actually land this cycle at the address being read
    fwd_hit     = (WRITE_FIRST != 0) && wr_en && !clear && (wr_addr == rd_addr);

    case (state_q)
      ST_SWEEP: begin
        // Strobes and clear are ignored; the array is zeroed one entry per cycle
        mem_we      = 1'b1;
        mem_waddr   = sweep_ptr_q;
        mem_wdata   = '0;
        sweep_ptr_d = sweep_ptr_q + ADDR_W'(1);
        if (&sweep_ptr_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        // The read always completes with pre-write (or forwarded) data,
        // even when a clear starts on the same edge
        if (rd_en) begin
          rd_valid_d = 1'b1;
          if (fwd_hit) begin
            rd_data_d = wr_data;
            rd_hit_d  = 1'b1;
          end else begin
            rd_data_d = mem_q[rd_addr];
            rd_hit_d  = valid_q[rd_addr];
          end
        end

        if (clear) begin
          // clear beats a simultaneous write
          state_d     = ST_SWEEP;
          sweep_ptr_d = '0;
          valid_d     = '0;
          count_d     = '0;
        end else if (wr_en) begin
          mem_we           = 1'b1;
          valid_d[wr_addr] = 1'b1;
          if (!valid_q[wr_addr]) begin
            count_d = count_q + (ADDR_W+1)'(1);
          end
        end
      end
    endcase
  end

  // Control and output registers; reset restarts the sweep from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SWEEP;
      sweep_ptr_q <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  // Storage array; contents are only cleared by the sweep, never by reset
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_hit   = rd_hit_q;
  assign busy     = (state_q == ST_SWEEP);
  assign count    = count_q;

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer: drives one stimulus stream into a read-old and a
// read-new instance and checks both against a behavioural model every cycle,
// plus literal expectations at the points of interest.
module tb_result_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0] rd_data0, rd_data1;
  logic              rd_valid0, rd_valid1;
  logic              rd_hit0, rd_hit1;
  logic              busy0, busy1;
  logic [ADDR_W:0]   count0, count1;

  int n_vec = 0;
  int n_err = 0;

  result_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(0)) u_wf0 (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_hit(rd_hit0),
    .busy(busy0), .count(count0)
  );

  result_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(1)) u_wf1 (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_hit(rd_hit1),
    .busy(busy1), .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic              started = 1'b0;
  int                busy_left = 0;
  logic [DATA_W-1:0] mmem [DEPTH];
  logic [DEPTH-1:0]  mvalid = '0;
  logic              exp_valid = 1'b0;
  logic [DATA_W-1:0] exp_data0 = '0, exp_data1 = '0;
  logic              exp_hit0 = 1'b0, exp_hit1 = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      started   = 1'b1;
      busy_left = DEPTH;
      exp_valid = 1'b0;
      exp_data0 = '0;
      exp_data1 = '0;
      exp_hit0  = 1'b0;
      exp_hit1  = 1'b0;
      mvalid    = '0;
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      exp_valid = 1'b0;
    end else begin
      exp_valid = rd_en;
      if (rd_en) begin
        exp_data0 = mmem[rd_addr];
        exp_hit0  = mvalid[rd_addr];
        if (wr_en && !clear && wr_addr == rd_addr) begin
          exp_data1 = wr_data;
          exp_hit1  = 1'b1;
        end else begin
          exp_data1 = mmem[rd_addr];
          exp_hit1  = mvalid[rd_addr];
        end
      end
      if (clear) begin
        busy_left = DEPTH;
        mvalid    = '0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      end else if (wr_en) begin
        mmem[wr_addr]   = wr_data;
        mvalid[wr_addr] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("busy_wf0",     32'(busy0),     32'(busy_left > 0));
      chk("busy_wf1",     32'(busy1),     32'(busy_left > 0));
      chk("count_wf0",    32'(count0),    32'($countones(mvalid)));
      chk("count_wf1",    32'(count1),    32'($countones(mvalid)));
      chk("rd_valid_wf0", 32'(rd_valid0), 32'(exp_valid));
      chk("rd_valid_wf1", 32'(rd_valid1), 32'(exp_valid));
      chk("rd_data_wf0",  32'(rd_data0),  32'(exp_data0));
      chk("rd_data_wf1",  32'(rd_data1),  32'(exp_data1));
      chk("rd_hit_wf0",   32'(rd_hit0),   32'(exp_hit0));
      chk("rd_hit_wf1",   32'(rd_hit1),   32'(exp_hit1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic busy_len(input string name);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk(name, 32'(n), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("reset_count",    32'(count0),    32'd0);
    chk("reset_rd_valid", 32'(rd_valid0), 32'd0);
    chk("reset_rd_data",  32'(rd_data0),  32'd0);
    chk("reset_busy",     32'(busy0),     32'd1);
    busy_len("reset_sweep_len");

    for (int i = 0; i < DEPTH; i++) rd(4'(i));
    chk("swept_rd_data", 32'(rd_data0),  32'h0000);
    chk("swept_rd_hit",  32'(rd_hit0),   32'd0);
    chk("swept_rd_vld",  32'(rd_valid0), 32'd1);

    // write / readback
    wr(4'd3, 16'hBEEF);
    wr(4'd15, 16'h1234);
    rd(4'd3);
    chk("readback_data",  32'(rd_data0),  32'hBEEF);
    chk("readback_valid", 32'(rd_valid0), 32'd1);
    chk("readback_hit",   32'(rd_hit0),   32'd1);
    chk("readback_count", 32'(count0),    32'd2);

    // hold after read
    repeat (4) tick();
    chk("hold_valid", 32'(rd_valid0), 32'd0);
    chk("hold_data",  32'(rd_data0),  32'hBEEF);
    chk("hold_hit",   32'(rd_hit0),   32'd1);

    // rewrite does not bump count
    wr(4'd3, 16'hAAAA);
    chk("rewrite_count", 32'(count0), 32'd2);
    rd(4'd3);
    chk("rewrite_data", 32'(rd_data0), 32'hAAAA);

    // read during write, same address, previously written
    wr(4'd5, 16'h1111);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_old_data", 32'(rd_data0), 32'h1111);
    chk("rdw_old_hit",  32'(rd_hit0),  32'd1);
    chk("rdw_new_data", 32'(rd_data1), 32'h2222);
    chk("rdw_new_hit",  32'(rd_hit1),  32'd1);
    chk("rdw_count",    32'(count0),   32'd3);

    // read during write, same address, never written
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h3333;
    rd_en = 1'b1; rd_addr = 4'd6;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_empty_old_data", 32'(rd_data0), 32'h0000);
    chk("rdw_empty_old_hit",  32'(rd_hit0),  32'd0);
    chk("rdw_empty_new_data", 32'(rd_data1), 32'h3333);
    chk("rdw_empty_new_hit",  32'(rd_hit1),  32'd1);

    // different addresses are independent
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h4444;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("indep_data_wf1", 32'(rd_data1), 32'h2222);
    chk("indep_count",    32'(count0),   32'd5);

    // fill every entry
    for (int i = 0; i < DEPTH; i++) wr(4'(i), 16'h0100 + 16'(i));
    chk("full_count", 32'(count0), 32'd16);

    // clear with simultaneous write and read of entry 7
    clear = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hDEAD;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("clear_rd_valid", 32'(rd_valid0), 32'd1);
    chk("clear_rd_data",  32'(rd_data0),  32'h0107);
    chk("clear_rd_hit",   32'(rd_hit0),   32'd1);
    chk("clear_busy",     32'(busy0),     32'd1);
    chk("clear_count",    32'(count0),    32'd0);
    busy_len("clear_sweep_len");
    for (int i = 0; i < DEPTH; i++) rd(4'(i));
    rd(4'd7);
    chk("cleared_data", 32'(rd_data0), 32'h0000);
    chk("cleared_hit",  32'(rd_hit0),  32'd0);

    // strobes and clear ignored mid-sweep, then reset restarts the sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (7) tick();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
    rd_en = 1'b1; rd_addr = 4'd2; clear = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    chk("busy_rd_valid", 32'(rd_valid0), 32'd0);
    chk("busy_count",    32'(count0),    32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len("restart_sweep_len");
    rd(4'd2);
    chk("blocked_wr_data",  32'(rd_data0), 32'h0000);
    chk("blocked_wr_hit",   32'(rd_hit0),  32'd0);
    chk("blocked_wr_count", 32'(count0),   32'd0);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
Name: result_buffer

Overview:
- Parametrised successor to the team's 16x16 result store: a single-clock result RAM with independent write and read ports.
- Adds a per-entry valid bit, an occupancy count, a selectable read-during-write mode, and a hardware clear sweep that zeroes the whole array after reset or on command.
- Sits between the arithmetic datapath (writer) and the display/readout logic (reader).

Parameters:
- DATA_W, 16, width of each stored word.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- WRITE_FIRST, 0:
  - 0 = same-address read during write returns the old word.
  - 1 = same-address read during write returns the new word.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high; starts a clear sweep.
- clear  in  1  single-cycle request to zero the array and all valid bits.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- rd_hit  out  1  valid bit of the entry read; qualified by rd_valid.
- busy  out  1  high while a clear sweep is in progress.
- count  out  ADDR_W+1  number of entries with valid bit set, range 0..DEPTH.

Behaviour:
- Reset (synchronous, active-high) values: rd_data=0, rd_valid=0, rd_hit=0, count=0, all valid bits=0.
  - State goes to SWEEP with sweep_ptr=0 and busy=1.
  - While rst stays high, the block holds in SWEEP with ptr=0.
- FSM has two states, SWEEP and IDLE.
  - SWEEP: each cycle writes 0 to mem[sweep_ptr] and increments sweep_ptr. On the cycle sweep_ptr==DEPTH-1, the next state is IDLE.
  - Sweep length is exactly DEPTH cycles after rst deasserts; busy is high for all of them.
  - IDLE: clear=1 enters SWEEP with ptr=0 and clears all valid bits and count in the same edge.
- While busy: wr_en and rd_en are ignored, rd_valid=0, and clear is ignored (no restart). rst mid-sweep restarts the sweep at ptr 0.
- Write in IDLE: on wr_en=1, mem[wr_addr] <= wr_data and valid[wr_addr] <= 1.
  - If that valid bit was previously 0, count increments by 1; otherwise count is unchanged.
  - count never exceeds DEPTH.
- clear and wr_en in the same IDLE cycle: clear wins and the write is dropped.
- Read in IDLE: rd_en in cycle N gives rd_data=mem[rd_addr], rd_hit=valid[rd_addr] and rd_valid=1 in cycle N+1. Latency is fixed at 1.
  - When rd_en=0, rd_valid=0 next cycle and rd_data/rd_hit hold their last values.
- Read and write to the same address in the same cycle:
  - WRITE_FIRST=0: rd_data = old contents and rd_hit = old valid bit.
  - WRITE_FIRST=1: rd_data = wr_data and rd_hit = 1.
  - Different addresses are fully independent.
- Read and clear in the same IDLE cycle: the read completes with pre-clear data (rd_valid=1 next cycle); subsequent cycles are busy.
- Address wrap: addresses are modulo DEPTH by width; no out-of-range case exists.
- The array is not otherwise reset; unswept contents are never visible because reads are blocked while busy.

Test Plan (DATA_W=16, ADDR_W=4):
- Reset sweep: rst high 3 cycles then low -> busy=1 for exactly 16 cycles, then 0. Reads of addr 0..15 return rd_data=0x0000, rd_hit=0. count=0.
- Write/readback: write 0xBEEF@3, then 0x1234@15, then rd_en addr 3 -> next cycle rd_data=0xBEEF, rd_valid=1, rd_hit=1, count=2. Rewrite 0xAAAA@3 -> count stays 2.
- Read-during-write on addr 5, holding 0x1111, with wr_data 0x2222:
  - WRITE_FIRST=0 -> rd_data=0x1111.
  - WRITE_FIRST=1 -> rd_data=0x2222, rd_hit=1.
- Clear command: fill all 16 entries (count=16), pulse clear together with wr_en to addr 7 -> write dropped, busy for 16 cycles, count=0, every read returns 0 with rd_hit=0.
- Busy blocking and mid-sweep reset: at sweep cycle 8, assert wr_en and rd_en -> no write, rd_valid=0. Assert rst at sweep cycle 10 -> sweep restarts; busy lasts 16 cycles after rst release.
- Hold behaviour: read addr 3, then idle 4 cycles with rd_en=0 -> rd_valid=0 and rd_data remains 0xBEEF.
